// File: rtl/spi_pkg.sv
// Shared types for the SPI target core: FSM state encoding and SPI mode bundle.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ACTIVE = 2'd2
  } spi_slv_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

endpackage

// File: rtl/spi_bit_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with a configurable reset level.
module spi_bit_sync #(
  parameter int unsigned STAGES  = 2,
  parameter bit          RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= {STAGES{RST_VAL}};
    else     sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave_core.sv
// SPI target: oversampled SCLK/CS_N/MOSI, MSB-first word deserialiser and MISO serialiser
// with a single-entry tx holding register behind a valid/ready port.
module spi_slave_core
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter bit          CPOL        = 1'b0,
  parameter bit          CPHA        = 1'b0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk_i,
  input  logic              cs_n_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              miso_oe_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              underrun_o
);

  localparam spi_mode_t       MODE     = '{cpol: CPOL, cpha: CPHA};
  localparam int unsigned     CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic sclk_s, cs_n_s, mosi_s;
  logic sclk_q, cs_n_q;

  spi_bit_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sync_sclk (
    .clk (clk), .rst (rst), .d (sclk_i), .q (sclk_s)
  );
  spi_bit_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (
    .clk (clk), .rst (rst), .d (cs_n_i), .q (cs_n_s)
  );
  spi_bit_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk (clk), .rst (rst), .d (mosi_i), .q (mosi_s)
  );

  spi_slv_state_e    state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [DATA_W-1:0] shift_tx_q;
  logic [DATA_W-2:0] shift_rx_q;
  logic [DATA_W-1:0] tx_buf_q;
  logic [DATA_W-1:0] rx_word;
  logic              rx_done_q;

  logic lead_edge, trail_edge, sample_edge, shift_edge, cs_fall;
  logic load_word, word_done, sample_act, shift_act, accept;

  assign lead_edge   = (sclk_s != MODE.cpol) && (sclk_q == MODE.cpol);
  assign trail_edge  = (sclk_s == MODE.cpol) && (sclk_q != MODE.cpol);
  assign sample_edge = MODE.cpha ? trail_edge : lead_edge;
  assign shift_edge  = MODE.cpha ? lead_edge  : trail_edge;
  assign cs_fall     = !cs_n_s && cs_n_q;
  assign accept      = tx_valid_i && tx_ready_o;
  assign rx_word     = {shift_rx_q, mosi_s};

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Deselect has priority over any edge seen in the same cycle.
  always_comb begin
    state_d    = state_q;
    load_word  = 1'b0;
    word_done  = 1'b0;
    sample_act = 1'b0;
    shift_act  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs_fall) state_d = LOAD;
      end
      LOAD: begin
        if (cs_n_s) begin
          state_d = IDLE;
        end else begin
          state_d   = ACTIVE;
          load_word = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_n_s) begin
          state_d = IDLE;
        end else begin
          sample_act = sample_edge;
          shift_act  = shift_edge;
          if (sample_edge && (bit_cnt_q == LAST_BIT)) begin
            word_done = 1'b1;
            load_word = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q     <= CPOL;
      cs_n_q     <= 1'b1;
      bit_cnt_q  <= '0;
      shift_tx_q <= '0;
      shift_rx_q <= '0;
      tx_buf_q   <= '0;
      rx_done_q  <= 1'b0;
      miso_o     <= 1'b0;
      miso_oe_o  <= 1'b0;
      tx_ready_o <= 1'b1;
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      sclk_q     <= sclk_s;
      cs_n_q     <= cs_n_s;
      miso_oe_o  <= (state_d != IDLE);
      rx_done_q  <= word_done;
      rx_valid_o <= rx_done_q;
      underrun_o <= load_word && tx_ready_o;

      // A load while the buffer is empty sees tx_ready_o=1 and sends all-ones.
      if (accept) begin
        tx_buf_q   <= tx_data_i;
        tx_ready_o <= 1'b0;
      end else if (load_word) begin
        tx_ready_o <= 1'b1;
      end

      if (load_word) begin
        shift_tx_q <= tx_ready_o ? '1 : tx_buf_q;
        if (!MODE.cpha) miso_o <= tx_ready_o ? 1'b1 : tx_buf_q[DATA_W-1];
      end else if (shift_act) begin
        if (MODE.cpha) begin
          miso_o     <= shift_tx_q[DATA_W-1];
          shift_tx_q <= {shift_tx_q[DATA_W-2:0], 1'b0};
        end else if (bit_cnt_q != '0) begin
          // Trailing edge right after a reload must keep the new MSB on the line.
          miso_o     <= shift_tx_q[DATA_W-2];
          shift_tx_q <= {shift_tx_q[DATA_W-2:0], 1'b0};
        end
      end

      if (sample_act) begin
        shift_rx_q <= rx_word[DATA_W-2:0];
        if (bit_cnt_q == LAST_BIT) begin
          rx_data_o <= rx_word;
          bit_cnt_q <= '0;
        end else begin
          bit_cnt_q <= bit_cnt_q + CNT_W'(1);
        end
      end else if (state_q != ACTIVE || cs_n_s) begin
        bit_cnt_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed + randomized bench: one core per SPI mode, bench-side master and word-level model.
module tb_spi_slave_core;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned SYNC   = 2;
  localparam int          HALF   = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sclk, cs_n, mosi, miso, miso_oe, tx_valid, tx_ready, rx_valid, underrun;
  logic [7:0] tx_data [4];
  logic [7:0] rx_data [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_core #(
      .DATA_W      (DATA_W),
      .CPOL        (1'(g / 2)),
      .CPHA        (1'(g % 2)),
      .SYNC_STAGES (SYNC)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .sclk_i     (sclk[g]),
      .cs_n_i     (cs_n[g]),
      .mosi_i     (mosi[g]),
      .miso_o     (miso[g]),
      .miso_oe_o  (miso_oe[g]),
      .tx_data_i  (tx_data[g]),
      .tx_valid_i (tx_valid[g]),
      .tx_ready_o (tx_ready[g]),
      .rx_data_o  (rx_data[g]),
      .rx_valid_o (rx_valid[g]),
      .underrun_o (underrun[g])
    );
  end

  int         errors = 0;
  int         checks = 0;
  int         rx_cnt [4] = '{default: 0};
  int         ur_cnt [4] = '{default: 0};
  logic [7:0] rx_hist [4][16];

  // Word-level model: the slave's tx buffer contents and what each load should send.
  logic       mdl_full [4];
  logic [7:0] mdl_buf  [4];
  logic [7:0] mo_w   [8];
  logic [7:0] tx_w   [8];
  logic [7:0] mi_got [8];
  logic [7:0] mi_exp [8];

  always @(negedge clk) begin
    for (int m = 0; m < 4; m++) begin
      if (rx_valid[m]) begin
        rx_hist[m][rx_cnt[m] % 16] <= rx_data[m];
        rx_cnt[m] <= rx_cnt[m] + 1;
      end
      if (underrun[m]) ur_cnt[m] <= ur_cnt[m] + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mdl_load(input int m, output logic [7:0] w, inout int exp_ur);
    if (mdl_full[m]) begin
      w = mdl_buf[m];
    end else begin
      w = 8'hFF;
      exp_ur++;
    end
    mdl_full[m] = 1'b0;
  endtask

  task automatic push_tx(input int m, input logic [7:0] d);
    int t = 0;
    while (!tx_ready[m] && t < 50) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("m%0d_tx_ready_wait", m), 32'(tx_ready[m]), 32'd1);
    if (tx_ready[m]) begin
      tx_data[m]  = d;
      tx_valid[m] = 1'b1;
      @(negedge clk);
      tx_valid[m] = 1'b0;
      mdl_buf[m]  = d;
      mdl_full[m] = 1'b1;
      check($sformatf("m%0d_tx_ready_drop", m), 32'(tx_ready[m]), 32'd0);
    end
  endtask

  task automatic wait_half(input int m, output int lat);
    lat = 0;
    for (int j = 1; j <= HALF; j++) begin
      @(negedge clk);
      if (rx_valid[m] && lat == 0) lat = j;
    end
  endtask

  task automatic check_reset_vals(input int m);
    check($sformatf("m%0d_rst_miso", m),     32'(miso[m]),     32'd0);
    check($sformatf("m%0d_rst_miso_oe", m),  32'(miso_oe[m]),  32'd0);
    check($sformatf("m%0d_rst_tx_ready", m), 32'(tx_ready[m]), 32'd1);
    check($sformatf("m%0d_rst_rx_data", m),  32'(rx_data[m]),  32'd0);
    check($sformatf("m%0d_rst_rx_valid", m), 32'(rx_valid[m]), 32'd0);
    check($sformatf("m%0d_rst_underrun", m), 32'(underrun[m]), 32'd0);
  endtask

  // Master-side frame: n words under one CS_N, optional cut of the last word (and reset).
  task automatic frame(input int m, input int n, input int cut_bits, input bit do_rst,
                       input bit preload);
    logic cpol, cpha;
    int   lat, nb, complete, rx0, ur0, exp_ur;
    cpol   = 1'(m / 2);
    cpha   = 1'(m % 2);
    exp_ur = 0;
    if (preload) push_tx(m, tx_w[0]);
    rx0 = rx_cnt[m];
    ur0 = ur_cnt[m];
    cs_n[m] = 1'b0;
    if (!cpha) mosi[m] = mo_w[0][7];
    mdl_load(m, mi_exp[0], exp_ur);
    repeat (10) @(negedge clk);
    check($sformatf("m%0d_miso_oe_sel", m), 32'(miso_oe[m]), 32'd1);
    for (int k = 0; k < n; k++) begin
      nb = (cut_bits > 0 && k == n - 1) ? cut_bits : 8;
      for (int i = 0; i < nb; i++) begin
        if (!cpha) begin
          mi_got[k][7-i] = miso[m];
          sclk[m] = ~cpol;
          wait_half(m, lat);
          if (i == 7) check($sformatf("m%0d_rx_latency", m), 32'(lat), 32'(SYNC + 2));
          sclk[m] = cpol;
          if (i < 7) mosi[m] = mo_w[k][6-i];
          else if (k + 1 < n) mosi[m] = mo_w[k+1][7];
          wait_half(m, lat);
        end else begin
          sclk[m] = ~cpol;
          mosi[m] = mo_w[k][7-i];
          wait_half(m, lat);
          mi_got[k][7-i] = miso[m];
          sclk[m] = cpol;
          wait_half(m, lat);
          if (i == 7) check($sformatf("m%0d_rx_latency", m), 32'(lat), 32'(SYNC + 2));
        end
        if (i == 1) push_tx(m, tx_w[k+1]);
      end
      if (nb == 8) mdl_load(m, mi_exp[k+1], exp_ur);
    end
    if (do_rst) begin
      rst     = 1'b1;
      cs_n[m] = 1'b1;
      @(negedge clk);
      check_reset_vals(m);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int q = 0; q < 4; q++) mdl_full[q] = 1'b0;
      repeat (4) @(negedge clk);
    end else begin
      cs_n[m] = 1'b1;
      repeat (10) @(negedge clk);
      check($sformatf("m%0d_miso_oe_desel", m), 32'(miso_oe[m]), 32'd0);
    end
    complete = (cut_bits > 0) ? n - 1 : n;
    check($sformatf("m%0d_rx_count", m), 32'(rx_cnt[m] - rx0), 32'(complete));
    for (int k = 0; k < complete; k++) begin
      check($sformatf("m%0d_rx_word%0d", m, k), 32'(rx_hist[m][(rx0 + k) % 16]), 32'(mo_w[k]));
      check($sformatf("m%0d_miso_word%0d", m, k), 32'(mi_got[k]), 32'(mi_exp[k]));
    end
    check($sformatf("m%0d_underrun_count", m), 32'(ur_cnt[m] - ur0), 32'(exp_ur));
  endtask

  initial begin
    int m;
    rst = 1'b1;
    for (int q = 0; q < 4; q++) begin
      sclk[q]     = 1'(q / 2);
      tx_data[q]  = 8'h00;
      mdl_full[q] = 1'b0;
      mdl_buf[q]  = 8'h00;
    end
    cs_n     = 4'hF;
    mosi     = 4'h0;
    tx_valid = 4'h0;
    repeat (4) @(negedge clk);
    for (int q = 0; q < 4; q++) check_reset_vals(q);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Mode 0, preloaded A5, master sends 3C.
    tx_w[0] = 8'hA5; tx_w[1] = 8'(($urandom));
    mo_w[0] = 8'h3C;
    frame(0, 1, 0, 1'b0, 1'b1);
    check("m0_miso_a5", 32'(mi_got[0]), 32'h0000_00A5);

    // All four modes: 81 in, 7E out.
    for (int q = 0; q < 4; q++) begin
      tx_w[0] = 8'h7E; tx_w[1] = 8'($urandom);
      mo_w[0] = 8'h81;
      frame(q, 1, 0, 1'b0, 1'b1);
      check($sformatf("m%0d_miso_7e", q), 32'(mi_got[0]), 32'h0000_007E);
    end

    // Empty buffer at CS_N fall.
    mo_w[0] = 8'($urandom); tx_w[1] = 8'($urandom);
    frame(0, 1, 0, 1'b0, 1'b0);
    check("m0_miso_ff", 32'(mi_got[0]), 32'h0000_00FF);

    // Three back-to-back words under one select.
    m = int'($urandom_range(0, 3));
    mo_w[0] = 8'h01; mo_w[1] = 8'h02; mo_w[2] = 8'h03;
    for (int k = 0; k < 4; k++) tx_w[k] = 8'($urandom);
    frame(m, 3, 0, 1'b0, 1'b1);

    // Deselect after 5 bits, then a full C3 transfer.
    m = int'($urandom_range(0, 3));
    mo_w[0] = 8'($urandom); tx_w[0] = 8'($urandom); tx_w[1] = 8'($urandom);
    frame(m, 1, 5, 1'b0, 1'b1);
    mo_w[0] = 8'hC3; tx_w[1] = 8'($urandom);
    frame(m, 1, 0, 1'b0, 1'b0);

    // Reset mid-word, then a full 55 transfer.
    m = int'($urandom_range(0, 3));
    mo_w[0] = 8'($urandom); tx_w[0] = 8'($urandom); tx_w[1] = 8'($urandom);
    frame(m, 1, 4, 1'b1, 1'b1);
    mo_w[0] = 8'h55; tx_w[0] = 8'($urandom); tx_w[1] = 8'($urandom);
    frame(m, 1, 0, 1'b0, 1'b1);

    // Random frames across modes.
    for (int r = 0; r < 8; r++) begin
      int n;
      m = int'($urandom_range(0, 3));
      n = int'($urandom_range(1, 3));
      for (int k = 0; k < 4; k++) begin
        mo_w[k] = 8'($urandom);
        tx_w[k] = 8'($urandom);
      end
      frame(m, n, 0, 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
